// File: rtl/prbs_chk_pkg.sv
// Shared types and helpers for the multi-lane PRBS checker: polynomial
// selection, lane states, a bit-serial-unrolled LFSR advance and popcount.
package prbs_chk_pkg;

    localparam int HIST_W   = 31;
    localparam int WORD_MAX = 32;

    typedef enum logic [1:0] {
        MODE_PRBS7  = 2'd0,
        MODE_PRBS15 = 2'd1,
        MODE_PRBS23 = 2'd2,
        MODE_PRBS31 = 2'd3
    } prbs_mode_e;

    typedef enum logic {
        LANE_SEARCH = 1'b0,
        LANE_LOCKED = 1'b1
    } lane_state_e;

    // Tap positions are stored as history indices (p-1, q-1); history bit 0 is the newest bit.
    typedef struct packed {
        logic [4:0] order;
        logic [4:0] p_idx;
        logic [4:0] q_idx;
    } taps_t;

    typedef struct packed {
        logic [HIST_W-1:0]   state;
        logic [WORD_MAX-1:0] miss;
    } step_t;

    function automatic taps_t mode_taps(input prbs_mode_e mode);
        taps_t t;
        case (mode)
            MODE_PRBS7:  t = '{order: 5'd7,  p_idx: 5'd6,  q_idx: 5'd5};
            MODE_PRBS15: t = '{order: 5'd15, p_idx: 5'd14, q_idx: 5'd13};
            MODE_PRBS23: t = '{order: 5'd23, p_idx: 5'd22, q_idx: 5'd17};
            default:     t = '{order: 5'd31, p_idx: 5'd30, q_idx: 5'd27};
        endcase
        return t;
    endfunction

    function automatic logic [4:0] mode_order(input prbs_mode_e mode);
        taps_t t;
        t = mode_taps(mode);
        return t.order;
    endfunction

    // Walks n_bits of word, MSB first. from_data=1 shifts received bits in
    // (self-synchronous check); from_data=0 shifts predictions in (free-running LFSR).
    function automatic step_t lfsr_advance(
        input logic [HIST_W-1:0]   state,
        input logic [WORD_MAX-1:0] word,
        input int                  n_bits,
        input prbs_mode_e          mode,
        input logic                from_data
    );
        taps_t               t;
        logic [HIST_W-1:0]   s;
        logic [WORD_MAX-1:0] miss;
        logic                pred;
        step_t               r;
        t    = mode_taps(mode);
        s    = state;
        miss = '0;
        for (int k = WORD_MAX - 1; k >= 0; k--) begin
            if (k < n_bits) begin
                pred    = s[t.p_idx] ^ s[t.q_idx];
                miss[k] = word[k] ^ pred;
                s       = {s[HIST_W-2:0], (from_data ? word[k] : pred)};
            end
        end
        r.state = s;
        r.miss  = miss;
        return r;
    endfunction

    function automatic logic [5:0] popcount(input logic [WORD_MAX-1:0] w);
        logic [5:0] c;
        c = '0;
        for (int k = 0; k < WORD_MAX; k++) begin
            c = c + {5'd0, w[k]};
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs_lane_chk.sv
// One PRBS checker lane: self-synchronous search, LFSR tracking once locked,
// loss-of-lock detection and a saturating bit-error counter.
module prbs_lane_chk
    import prbs_chk_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 16,
    parameter int LOCK_CNT    = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic              mode_change_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              lock_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    localparam int CLEAN_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W   = $clog2(LOSS_THRESH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0] FILL_7  = 4'((7  + DATA_W - 1) / DATA_W);
    localparam logic [3:0] FILL_15 = 4'((15 + DATA_W - 1) / DATA_W);
    localparam logic [3:0] FILL_23 = 4'((23 + DATA_W - 1) / DATA_W);
    localparam logic [3:0] FILL_31 = 4'((31 + DATA_W - 1) / DATA_W);

    lane_state_e          state_reg, state_next;
    logic [HIST_W-1:0]    hist_reg, hist_next;
    logic [HIST_W-1:0]    lfsr_reg, lfsr_next;
    logic [3:0]           fill_reg, fill_next;
    logic [CLEAN_W-1:0]   clean_reg, clean_next;
    logic [BAD_W-1:0]     bad_reg, bad_next;
    logic                 err_reg, err_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;

    prbs_mode_e           mode_sel;
    logic [WORD_MAX-1:0]  word_ext;
    step_t                hist_step, lfsr_step;
    logic [5:0]           pop;
    logic [3:0]           fill_target;
    logic [HIST_W-1:0]    order_mask;
    logic [CNT_W+5:0]     cnt_sum;

    always_comb begin
        word_ext              = '0;
        word_ext[DATA_W-1:0]  = data_i;
    end

    assign mode_sel   = prbs_mode_e'(mode_i);
    assign hist_step  = lfsr_advance(hist_reg, word_ext, DATA_W, mode_sel, 1'b1);
    assign lfsr_step  = lfsr_advance(lfsr_reg, word_ext, DATA_W, mode_sel, 1'b0);
    assign pop        = popcount(lfsr_step.miss);
    assign order_mask = ~({HIST_W{1'b1}} << mode_order(mode_sel));
    assign cnt_sum    = {6'd0, cnt_reg} + {{CNT_W{1'b0}}, pop};

    always_comb begin
        case (mode_sel)
            MODE_PRBS7:  fill_target = FILL_7;
            MODE_PRBS15: fill_target = FILL_15;
            MODE_PRBS23: fill_target = FILL_23;
            default:     fill_target = FILL_31;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        hist_next  = hist_reg;
        lfsr_next  = lfsr_reg;
        fill_next  = fill_reg;
        clean_next = clean_reg;
        bad_next   = bad_reg;
        err_next   = 1'b0;
        cnt_next   = cnt_reg;

        if (!en_i || mode_change_i) begin
            state_next = LANE_SEARCH;
            fill_next  = '0;
            clean_next = '0;
            bad_next   = '0;
        end else if (valid_i) begin
            hist_next = hist_step.state;
            case (state_reg)
                LANE_SEARCH: begin
                    if (fill_reg < fill_target) begin
                        fill_next = fill_reg + 4'd1;
                    end else if (hist_step.miss != '0) begin
                        clean_next = '0;
                    end else if (clean_reg + 1'b1 == CLEAN_W'(LOCK_CNT)) begin
                        // An all-zero state satisfies the recurrence but is not a PRBS
                        clean_next = '0;
                        if ((hist_step.state & order_mask) != '0) begin
                            state_next = LANE_LOCKED;
                            lfsr_next  = hist_step.state;
                            bad_next   = '0;
                        end
                    end else begin
                        clean_next = clean_reg + 1'b1;
                    end
                end
                default: begin
                    lfsr_next = lfsr_step.state;
                    cnt_next  = (cnt_sum > {6'd0, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
                    if (pop != 6'd0) begin
                        err_next = 1'b1;
                        if (bad_reg + 1'b1 == BAD_W'(LOSS_THRESH)) begin
                            state_next = LANE_SEARCH;
                            fill_next  = '0;
                            clean_next = '0;
                            bad_next   = '0;
                        end else begin
                            bad_next = bad_reg + 1'b1;
                        end
                    end else begin
                        bad_next = '0;
                    end
                end
            endcase
        end

        if (clear_i) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_reg <= LANE_SEARCH;
            hist_reg  <= '0;
            lfsr_reg  <= '0;
            fill_reg  <= '0;
            clean_reg <= '0;
            bad_reg   <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            hist_reg  <= hist_next;
            lfsr_reg  <= lfsr_next;
            fill_reg  <= fill_next;
            clean_reg <= clean_next;
            bad_reg   <= bad_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign lock_o    = (state_reg == LANE_LOCKED);
    assign err_o     = err_reg;
    assign err_cnt_o = cnt_reg;

endmodule

// File: rtl/prbs_lane_checker.sv
// Multi-lane PRBS checker top: optional per-lane bit reversal, shared mode
// change detection and one independent checker per lane.
module prbs_lane_checker
    import prbs_chk_pkg::*;
#(
    parameter int N_LANES     = 4,
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 16,
    parameter int LOCK_CNT    = 16,
    parameter int LOSS_THRESH = 4,
    parameter int BIT_REV     = 0
) (
    input  logic                      clk_i,
    input  logic                      resetn_i,
    input  logic                      en_i,
    input  logic [1:0]                mode_i,
    input  logic                      clear_i,
    input  logic                      data_valid_i,
    input  logic [N_LANES*DATA_W-1:0] data_in_i,
    output logic [N_LANES-1:0]        lock_o,
    output logic [N_LANES-1:0]        err_o,
    output logic [N_LANES*CNT_W-1:0]  err_cnt_o,
    output logic                      all_locked_o
);

    logic [1:0] mode_reg;
    logic       mode_change;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            mode_reg <= MODE_PRBS7;
        end else begin
            mode_reg <= mode_i;
        end
    end

    assign mode_change = (mode_i != mode_reg);

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] lane_word;

            always_comb begin
                for (int b = 0; b < DATA_W; b++) begin
                    lane_word[b] = (BIT_REV != 0) ? data_in_i[gi*DATA_W + DATA_W - 1 - b]
                                                  : data_in_i[gi*DATA_W + b];
                end
            end

            prbs_lane_chk #(
                .DATA_W      (DATA_W),
                .CNT_W       (CNT_W),
                .LOCK_CNT    (LOCK_CNT),
                .LOSS_THRESH (LOSS_THRESH)
            ) u_lane (
                .clk_i         (clk_i),
                .resetn_i      (resetn_i),
                .en_i          (en_i),
                .mode_i        (mode_i),
                .mode_change_i (mode_change),
                .clear_i       (clear_i),
                .valid_i       (data_valid_i),
                .data_i        (lane_word),
                .lock_o        (lock_o[gi]),
                .err_o         (err_o[gi]),
                .err_cnt_o     (err_cnt_o[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign all_locked_o = &lock_o;

endmodule

// File: tb/tb_prbs_lane_checker.sv
// Directed bench for prbs_lane_checker: 4 lanes x 8 bits, 4-bit counters,
// lock after 16 clean words, loss after 4 errored words.
module tb_prbs_lane_checker;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [1:0]  mode;
    logic        clear;
    logic        valid;
    logic [31:0] din;
    logic [3:0]  lock;
    logic [3:0]  err;
    logic [15:0] cnt;
    logic        all_locked;

    int checks = 0;
    int errors = 0;
    logic [30:0] gen_reg [4];
    int tp;
    int tq;

    always #5 clk = ~clk;

    prbs_lane_checker #(
        .N_LANES     (4),
        .DATA_W      (8),
        .CNT_W       (4),
        .LOCK_CNT    (16),
        .LOSS_THRESH (4),
        .BIT_REV     (0)
    ) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .en_i         (en),
        .mode_i       (mode),
        .clear_i      (clear),
        .data_valid_i (valid),
        .data_in_i    (din),
        .lock_o       (lock),
        .err_o        (err),
        .err_cnt_o    (cnt),
        .all_locked_o (all_locked)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reseed the stimulus generators; b[n] = b[n-tp] ^ b[n-tq]
    task automatic gen_mode(input int m);
        case (m)
            0:       begin tp = 7;  tq = 6;  end
            1:       begin tp = 15; tq = 14; end
            2:       begin tp = 23; tq = 18; end
            default: begin tp = 31; tq = 28; end
        endcase
        gen_reg[0] = 31'h0000_0001;
        gen_reg[1] = 31'h1234_567B;
        gen_reg[2] = 31'h0ACE_1359;
        gen_reg[3] = 31'h5555_5555;
    endtask

    task automatic send_beat(input logic [31:0] flip, input logic zero);
        logic [31:0] w;
        logic        nb;
        w = '0;
        if (!zero) begin
            for (int k = 0; k < 4; k++) begin
                for (int i = 7; i >= 0; i--) begin
                    nb = gen_reg[k][tp-1] ^ gen_reg[k][tq-1];
                    w[k*8 + i] = nb;
                    gen_reg[k] = {gen_reg[k][29:0], nb};
                end
            end
        end
        valid = 1'b1;
        din   = w ^ flip;
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n);
        for (int j = 0; j < n; j++) send_beat(32'h0, 1'b0);
    endtask

    task automatic idle_cycle();
        valid = 1'b0;
        din   = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        en     = 1'b0;
        mode   = 2'd0;
        clear  = 1'b0;
        valid  = 1'b0;
        din    = '0;
        gen_mode(0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_lock", 32'(lock), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        check_eq("rst_cnt", 32'(cnt), 32'h0);
        check_eq("rst_all", 32'(all_locked), 32'h0);
        resetn = 1'b1;
        en     = 1'b1;

        // Clean PRBS7: 1 fill beat + 16 clean beats
        send_n(16);
        check_eq("p7_lock_early", 32'(lock), 32'h0);
        send_beat(32'h0, 1'b0);
        check_eq("p7_lock", 32'(lock), 32'hF);
        check_eq("p7_all", 32'(all_locked), 32'h1);
        check_eq("p7_cnt", 32'(cnt), 32'h0);

        // Three flipped bits on lane 2
        send_beat(32'h00A1_0000, 1'b0);
        check_eq("l2_err", 32'(err), 32'h4);
        check_eq("l2_cnt", 32'(cnt), 32'h0300);
        check_eq("l2_lock", 32'(lock), 32'hF);
        send_beat(32'h0, 1'b0);
        check_eq("l2_err_pulse", 32'(err), 32'h0);
        check_eq("l2_cnt_hold", 32'(cnt), 32'h0300);

        // Lane 0 loses lock after four errored beats, then relocks
        repeat (3) send_beat(32'h0000_0001, 1'b0);
        check_eq("l0_still_lock", 32'(lock), 32'hF);
        send_beat(32'h0000_0001, 1'b0);
        check_eq("l0_loss", 32'(lock), 32'hE);
        check_eq("l0_loss_all", 32'(all_locked), 32'h0);
        check_eq("l0_cnt", 32'(cnt), 32'h0304);
        send_n(16);
        check_eq("l0_relock_early", 32'(lock), 32'hE);
        send_beat(32'h0, 1'b0);
        check_eq("l0_relock", 32'(lock), 32'hF);
        check_eq("l0_cnt_kept", 32'(cnt), 32'h0304);

        // Lane 1 saturation, then clear beats a same-cycle increment
        for (int j = 0; j < 20; j++) begin
            send_beat(32'h0000_1000, 1'b0);
            send_beat(32'h0, 1'b0);
        end
        check_eq("sat_cnt", 32'(cnt), 32'h03F4);
        check_eq("sat_lock", 32'(lock), 32'hF);
        clear = 1'b1;
        send_beat(32'h0000_1000, 1'b0);
        clear = 1'b0;
        check_eq("clr_cnt", 32'(cnt), 32'h0);
        check_eq("clr_err", 32'(err), 32'h2);
        check_eq("clr_lock", 32'(lock), 32'hF);

        // PRBS31 lock: 4 fill + 16 clean
        mode = 2'd3;
        gen_mode(3);
        idle_cycle();
        check_eq("m31_drop", 32'(lock), 32'h0);
        send_n(19);
        check_eq("m31_lock_early", 32'(lock), 32'h0);
        send_beat(32'h0, 1'b0);
        check_eq("m31_lock", 32'(lock), 32'hF);
        check_eq("m31_cnt", 32'(cnt), 32'h0);

        // Switch to PRBS15 on a valid beat: 2 fill + 16 clean
        mode = 2'd1;
        send_beat(32'h0, 1'b0);
        check_eq("m15_drop", 32'(lock), 32'h0);
        gen_mode(1);
        send_n(17);
        check_eq("m15_lock_early", 32'(lock), 32'h0);
        send_beat(32'h0, 1'b0);
        check_eq("m15_lock", 32'(lock), 32'hF);

        // All-zero input never locks
        mode = 2'd0;
        idle_cycle();
        check_eq("zero_drop", 32'(lock), 32'h0);
        repeat (100) send_beat(32'h0, 1'b1);
        check_eq("zero_p7", 32'(lock), 32'h0);
        mode = 2'd3;
        idle_cycle();
        repeat (100) send_beat(32'h0, 1'b1);
        check_eq("zero_p31", 32'(lock), 32'h0);
        check_eq("zero_cnt", 32'(cnt), 32'h0);

        // Enable toggle mid-lock
        mode = 2'd0;
        gen_mode(0);
        idle_cycle();
        send_n(17);
        check_eq("en_lock", 32'(lock), 32'hF);
        send_beat(32'h0100_0000, 1'b0);
        check_eq("en_err", 32'(err), 32'h8);
        check_eq("en_cnt", 32'(cnt), 32'h1000);
        en = 1'b0;
        send_beat(32'h0100_0000, 1'b0);
        check_eq("dis_lock", 32'(lock), 32'h0);
        check_eq("dis_err", 32'(err), 32'h0);
        check_eq("dis_cnt", 32'(cnt), 32'h1000);
        repeat (3) send_beat(32'hFF00_0000, 1'b0);
        check_eq("dis_cnt_frozen", 32'(cnt), 32'h1000);
        en = 1'b1;
        send_n(16);
        check_eq("ren_lock_early", 32'(lock), 32'h0);
        send_beat(32'h0, 1'b0);
        check_eq("ren_lock", 32'(lock), 32'hF);
        check_eq("ren_cnt", 32'(cnt), 32'h1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs_lane_checker.md
Name: prbs_lane_checker

Overview:
- Parametrised multi-lane PRBS checker. It is the successor to the fixed 8-bit, single-polynomial fabric PRBS checker used in the RX IOD bit-alignment test harness.
- Sits after the per-lane bit-reversal stage, in the RX_CLK_G domain. Each lane checks one deserialised RXIOD lane.
- Adds selectable polynomial, self-synchronising lock acquisition, loss-of-lock detection and saturating per-lane bit-error counters.

Parameters:
- N_LANES, 4, number of independent lanes.
- DATA_W, 8, bits per lane per valid beat (4..32).
- CNT_W, 16, error-counter width per lane.
- LOCK_CNT, 16, consecutive clean words in SEARCH required to lock (≥1).
- LOSS_THRESH, 4, consecutive errored words in LOCKED that force return to SEARCH (≥1).
- BIT_REV, 0, 1 = reverse bit order of each lane word before checking.

Ports:
- clk_i, in, 1, lane parallel clock (RX_CLK_G).
- resetn_i, in, 1, asynchronous active-low reset.
- en_i, in, 1, checker enable; 0 holds all lanes in SEARCH with counters frozen.
- mode_i, in, 2, polynomial select: 0=PRBS7 (x7+x6+1), 1=PRBS15 (x15+x14+1), 2=PRBS23 (x23+x18+1), 3=PRBS31 (x31+x28+1).
- clear_i, in, 1, synchronous clear of all error counters.
- data_valid_i, in, 1, data_in_i holds a valid beat this cycle.
- data_in_i, in, N_LANES*DATA_W, lane k occupies bits [k*DATA_W +: DATA_W]; the MSB is the earliest bit.
- lock_o, out, N_LANES, lane k is in LOCKED.
- err_o, out, N_LANES, one-cycle pulse when lane k detected ≥1 bit error in a LOCKED beat.
- err_cnt_o, out, N_LANES*CNT_W, saturating bit-error count per lane.
- all_locked_o, out, 1, AND of lock_o.

Behaviour:
- Reset: all lanes go to SEARCH; history, LFSR and counters are zeroed; lock_o, err_o, err_cnt_o and all_locked_o are 0.
- Per-lane state machine, states SEARCH and LOCKED. It advances only on data_valid_i=1 && en_i=1; otherwise all state holds.
- History register: per lane, 31 bits holding the last received bits, shifted by DATA_W on each valid beat.
- Fill counter: per lane, counts beats until ceil(order/DATA_W) beats have been absorbed after entering SEARCH. Until the fill count is reached, beats are neither compared nor counted.
- SEARCH, self-synchronous check: each received bit b[n] is compared against b[n-p] XOR b[n-q] for the mode taps (p,q), using history plus the earlier bits of the same word.
  - A clean word increments clean_cnt.
  - Any mismatch resets clean_cnt to 0.
  - When clean_cnt reaches LOCK_CNT, the lane enters LOCKED and the internal LFSR is loaded from the newest `order` received bits.
- LOCKED: the LFSR advances DATA_W steps per beat. This is the parallel next-state, computed by an unrolled loop. The received word is compared against the LFSR output.
  - Popcount of the mismatch word is added to err_cnt, saturating at 2^CNT_W-1, with no wrap.
  - err_o pulses if popcount is >0.
  - bad_cnt increments on an errored word and resets to 0 on a clean word.
  - When bad_cnt reaches LOSS_THRESH, the lane goes to SEARCH: clean_cnt and fill are reset, err_cnt is kept.
- Latency: lock_o, err_o and err_cnt_o update on the clock edge after the data_valid_i beat (1-cycle registered).
- Errors are never counted in SEARCH.
- mode_i change, detected by comparing against a registered copy: all lanes go to SEARCH the next cycle. Counters are not cleared.
- en_i=0: all lanes go to SEARCH; err_o=0; counters hold.
- clear_i=1: all err_cnt go to 0 the next cycle and take priority over any same-cycle increment. Lock state is unaffected.
- Lanes are fully independent except for the shared mode, en and clear.
- All-zero input never locks under PRBS, because the self-sync check passes but the LFSR loaded with zero is illegal. The implementation must therefore gate the SEARCH→LOCKED transition on a nonzero loaded state: if the state is zero, clean_cnt is reset.

Decomposition:
- Package prbs_chk_pkg holds:
  - mode enum (PRBS7/15/23/31);
  - order and tap constants per mode, plus a function returning (order, p, q);
  - lane state enum {SEARCH, LOCKED};
  - a parallel LFSR-advance function and a popcount function.
- One sub-module, prbs_lane_chk, implements one lane: history, FSM, LFSR and counter.
- The top generates N_LANES instances, applies BIT_REV slicing, and forms all_locked_o.

Test Plan:
- Clean PRBS7, DATA_W=8, LOCK_CNT=16, 4 lanes, continuous valid: lock_o=4'hF and all_locked_o=1 one cycle after the 17th beat (1 fill beat + 16 clean beats); err_cnt stays 0.
- Locked lane 2, flip 3 bits in one beat: err_o[2] pulses for exactly 1 cycle; err_cnt lane2=3; lock_o[2] is held; the other lanes are unaffected.
- Locked lane 0, corrupt 4 consecutive beats (LOSS_THRESH=4): lock_o[0] drops after the 4th beat; relock occurs after 1+16 clean beats; err_cnt is retained.
- CNT_W=4, inject 20 single-bit errors: err_cnt saturates at 15. Then assert clear_i in the same cycle as an errored beat: the counter reads 0.
- Locked under PRBS31 (DATA_W=8, 4 fill beats), switch mode_i to 1: all lock_o=0 the next cycle. Feeding PRBS15 relocks after 2+16 beats.
- All-zero input in any mode for 100 beats: lock_o stays 0. Toggling en_i mid-lock drops lock and freezes the counters.
